// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state and access-owner encodings.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    CORE = 1'b0,
    LDR  = 1'b1
  } owner_t;

  // Wide enough for WAIT_CYCLES-1 with WAIT_CYCLES up to 15
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundles the core port, loader/debug port and data-memory port of the arbiter.
interface dmem_arbiter_if;

  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_done;
  logic        core_stall;

  logic        ldr_req;
  logic        ldr_we;
  logic [31:0] ldr_addr;
  logic [31:0] ldr_wdata;
  logic [31:0] ldr_rdata;
  logic        ldr_ack;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_done, core_stall,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_rdata, ldr_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_done, core_stall,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_rdata, ldr_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_wait_counter.sv
// Down-counter timing the memory access window; zero marks the last access cycle.
module dmem_wait_counter
  import dmem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  dec,
  input  logic [WAIT_CNT_W-1:0] load_value,
  output logic                  zero
);

  logic [WAIT_CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (core vs loader/debug) with fixed-length accesses.
// Optional loader anti-starvation: define DMEM_ARB_FAIR_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [WAIT_CNT_W-1:0] LOAD_VALUE = WAIT_CNT_W'(WAIT_CYCLES - 1);

  arb_state_t state;
  owner_t     owner;
  owner_t     next_owner;
  logic       any_req;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;

  assign any_req  = bus.core_req | bus.ldr_req;
  assign cnt_load = (state == IDLE) && any_req;
  assign cnt_dec  = (state == ACCESS) && !cnt_zero;

  dmem_wait_counter u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (LOAD_VALUE),
    .zero       (cnt_zero)
  );

`ifdef DMEM_ARB_FAIR_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt;
  logic                starved;

  assign starved    = bus.ldr_req && (starve_cnt >= STARVE_W'(STARVE_LIMIT));
  assign next_owner = (bus.ldr_req && (!bus.core_req || starved)) ? LDR : CORE;

  // Counts core grants that overtook a waiting loader; only moves at arbitration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if ((state == IDLE) && any_req) begin
      if ((next_owner == LDR) || !bus.ldr_req) begin
        starve_cnt <= '0;
      end else begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  assign next_owner = bus.core_req ? CORE : LDR;
`endif

  // Request inputs are only looked at in IDLE; the rest of the access runs on latched values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      owner          <= CORE;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.core_rdata <= '0;
      bus.ldr_rdata  <= '0;
      bus.core_done  <= 1'b0;
      bus.ldr_ack    <= 1'b0;
    end else begin
      bus.core_done <= 1'b0;
      bus.ldr_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= next_owner;
            state      <= ACCESS;
            bus.mem_en <= 1'b1;
            if (next_owner == LDR) begin
              bus.mem_we    <= bus.ldr_we;
              bus.mem_addr  <= bus.ldr_addr;
              bus.mem_wdata <= bus.ldr_wdata;
            end else begin
              bus.mem_we    <= bus.core_we;
              bus.mem_addr  <= bus.core_addr;
              bus.mem_wdata <= bus.core_wdata;
            end
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            state      <= RESP;
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            if (!bus.mem_we) begin
              if (owner == LDR) begin
                bus.ldr_rdata <= bus.mem_rdata;
              end else begin
                bus.core_rdata <= bus.mem_rdata;
              end
            end
            if (owner == LDR) begin
              bus.ldr_ack <= 1'b1;
            end else begin
              bus.core_done <= 1'b1;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.core_stall = bus.core_req & ~bus.core_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level timing model.
module tb_dmem_arbiter;

  localparam int W  = 2;
  localparam int SL = 4;
`ifdef DMEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .WAIT_CYCLES  (W),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model of the current transaction: arbitration cycle, owner and latched fields
  int          cyc;
  bit          m_busy;
  int          m_a;
  int          m_next;
  bit          m_owner;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_pend;
  logic [31:0] m_core_rdata;
  logic [31:0] m_ldr_rdata;
  int          m_starve;

  task automatic idle_inputs();
    bus.core_req   = 1'b0;
    bus.core_we    = 1'b0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.ldr_req    = 1'b0;
    bus.ldr_we     = 1'b0;
    bus.ldr_addr   = '0;
    bus.ldr_wdata  = '0;
    bus.mem_rdata  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
    m_busy = 1'b0;
    m_a = 0;
    m_next = 0;
    m_owner = 1'b0;
    m_we = 1'b0;
    m_core_rdata = '0;
    m_ldr_rdata = '0;
    m_starve = 0;
  endtask

  task automatic test_reset();
    logic [31:0] got [10];
    string       names [10];
    rst = 1'b0;
    idle_inputs();
    tick();
    got   = '{32'(bus.mem_en), 32'(bus.mem_we), bus.mem_addr, bus.mem_wdata, bus.core_rdata,
              bus.ldr_rdata, 32'(bus.core_done), 32'(bus.ldr_ack), 32'(bus.core_stall), 32'(dut.state)};
    names = '{"mem_en", "mem_we", "mem_addr", "mem_wdata", "core_rdata",
              "ldr_rdata", "core_done", "ldr_ack", "core_stall", "state"};
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (got[i] !== 32'd0) begin
        fails++;
        $display("[TB] FAIL reset_%s got=%h expected=0", names[i], got[i]);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_core_read();
    do_reset();
    bus.core_req  = 1'b1;
    bus.core_we   = 1'b0;
    bus.core_addr = 32'h0000_0010;
    bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    tests_run++;
    if (bus.core_stall !== 1'b1) begin
      fails++;
      $display("[TB] FAIL read_stall_c0 got=%b expected=1", bus.core_stall);
    end
    for (int k = 1; k <= W + 1; k++) begin
      tick();
      tests_run += 3;
      if (bus.mem_en !== (k <= W)) begin
        fails++;
        $display("[TB] FAIL read_mem_en c%0d got=%b expected=%b", k, bus.mem_en, (k <= W));
      end
      if (bus.core_done !== (k == W + 1)) begin
        fails++;
        $display("[TB] FAIL read_done c%0d got=%b expected=%b", k, bus.core_done, (k == W + 1));
      end
      if (bus.core_stall !== (k != W + 1)) begin
        fails++;
        $display("[TB] FAIL read_stall c%0d got=%b expected=%b", k, bus.core_stall, (k != W + 1));
      end
      if (k == 1) begin
        tests_run++;
        if (bus.mem_addr !== 32'h0000_0010) begin
          fails++;
          $display("[TB] FAIL read_addr got=%h expected=00000010", bus.mem_addr);
        end
      end
    end
    tests_run++;
    if (bus.core_rdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("[TB] FAIL read_rdata got=%h expected=deadbeef", bus.core_rdata);
    end
    bus.core_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.core_req  = 1'b1;
    bus.core_addr = 32'h20;
    bus.ldr_req   = 1'b1;
    bus.ldr_addr  = 32'h80;
    for (int k = 1; k <= 8; k++) begin
      tick();
      tests_run += 2;
      if (bus.core_done !== (k == 3)) begin
        fails++;
        $display("[TB] FAIL simul_core_done c%0d got=%b expected=%b", k, bus.core_done, (k == 3));
      end
      if (bus.ldr_ack !== (k == 7)) begin
        fails++;
        $display("[TB] FAIL simul_ldr_ack c%0d got=%b expected=%b", k, bus.ldr_ack, (k == 7));
      end
      if (k == 5) begin
        tests_run++;
        if (bus.mem_addr !== 32'h80) begin
          fails++;
          $display("[TB] FAIL simul_ldr_addr got=%h expected=00000080", bus.mem_addr);
        end
      end
      if (k == 3) bus.core_req = 1'b0;
      if (k == 7) bus.ldr_req = 1'b0;
    end
  endtask

  task automatic test_loader_write();
    do_reset();
    bus.ldr_req   = 1'b1;
    bus.ldr_we    = 1'b1;
    bus.ldr_addr  = 32'h40;
    bus.ldr_wdata = 32'h1234_5678;
    bus.mem_rdata = 32'hA5A5_5A5A;
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests_run += 4;
      if (bus.mem_en !== (k <= W)) begin
        fails++;
        $display("[TB] FAIL wr_mem_en c%0d got=%b expected=%b", k, bus.mem_en, (k <= W));
      end
      if (bus.mem_we !== (k <= W)) begin
        fails++;
        $display("[TB] FAIL wr_mem_we c%0d got=%b expected=%b", k, bus.mem_we, (k <= W));
      end
      if (bus.ldr_ack !== (k == W + 1)) begin
        fails++;
        $display("[TB] FAIL wr_ack c%0d got=%b expected=%b", k, bus.ldr_ack, (k == W + 1));
      end
      if (bus.ldr_rdata !== 32'd0) begin
        fails++;
        $display("[TB] FAIL wr_ldr_rdata c%0d got=%h expected=0", k, bus.ldr_rdata);
      end
      if (k <= W) begin
        tests_run++;
        if ((bus.mem_addr !== 32'h40) || (bus.mem_wdata !== 32'h1234_5678)) begin
          fails++;
          $display("[TB] FAIL wr_bus c%0d got=%h/%h expected=00000040/12345678", k, bus.mem_addr, bus.mem_wdata);
        end
      end
      if (k == W + 1) bus.ldr_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    bus.core_req  = 1'b1;
    bus.core_addr = 32'h10;
    bus.mem_rdata = 32'h5555_AAAA;
    tick();
    tick();
    #2;
    rst = 1'b0;
    bus.core_req = 1'b0;
    #1;
    tests_run++;
    if ({bus.mem_en, bus.mem_we, bus.core_done, bus.ldr_ack, bus.core_stall} !== 5'b0 ||
        bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0 || bus.core_rdata !== 32'd0) begin
      fails++;
      $display("[TB] FAIL async_reset en=%b we=%b done=%b addr=%h rdata=%h expected all 0",
               bus.mem_en, bus.mem_we, bus.core_done, bus.mem_addr, bus.core_rdata);
    end
    tick();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests_run++;
      if (bus.core_done !== 1'b0 || bus.core_rdata !== 32'd0 || bus.mem_en !== 1'b0) begin
        fails++;
        $display("[TB] FAIL post_reset c%0d done=%b rdata=%h en=%b expected 0/0/0",
                 k, bus.core_done, bus.core_rdata, bus.mem_en);
      end
    end
  endtask

  task automatic test_drop_mid_access();
    int pulses;
    int at;
    do_reset();
    pulses = 0;
    at = -1;
    bus.core_req = 1'b1;
    bus.core_addr = 32'h44;
    for (int k = 1; k <= 6; k++) begin
      tick();
      bus.core_req = 1'b0;
      if (bus.core_done === 1'b1) begin
        pulses++;
        at = k;
      end
    end
    tests_run += 2;
    if (pulses != 1) begin
      fails++;
      $display("[TB] FAIL drop_pulses got=%0d expected=1", pulses);
    end
    if (at != W + 1) begin
      fails++;
      $display("[TB] FAIL drop_pulse_cycle got=%0d expected=%0d", at, W + 1);
    end
  endtask

  task automatic test_starvation();
    bit got_own [$];
    bit exp_own;
    do_reset();
    bus.core_req = 1'b1;
    bus.ldr_req  = 1'b1;
    for (int k = 0; k < 200 && got_own.size() < 10; k++) begin
      tick();
      if (bus.core_done === 1'b1) got_own.push_back(1'b0);
      if (bus.ldr_ack === 1'b1) got_own.push_back(1'b1);
    end
    tests_run++;
    if (got_own.size() < 10) begin
      fails++;
      $display("[TB] FAIL starve_timeout grants=%0d expected=10", got_own.size());
    end
    for (int i = 0; i < got_own.size(); i++) begin
      exp_own = FAIR && ((i % (SL + 1)) == SL);
      tests_run++;
      if (got_own[i] !== exp_own) begin
        fails++;
        $display("[TB] FAIL starve_grant%0d got=%b expected=%b", i, got_own[i], exp_own);
      end
    end
  endtask

  // Randomized traffic; the model only knows arbitration rules and cycle offsets
  task automatic test_random(input int n, input int pc, input int pl);
    bit exp_en, exp_cd, exp_la, resp;
    do_reset();
    for (int i = 0; i < n; i++) begin
      exp_en = m_busy && (cyc >= m_a + 1) && (cyc <= m_a + W);
      resp   = m_busy && (cyc == m_a + W + 1);
      exp_cd = resp && !m_owner;
      exp_la = resp && m_owner;
      if (resp && !m_we) begin
        if (m_owner) m_ldr_rdata = m_pend;
        else m_core_rdata = m_pend;
      end
      tests_run += 6;
      if (bus.mem_en !== exp_en) begin
        fails++;
        $display("[TB] FAIL rnd_mem_en c%0d got=%b expected=%b", cyc, bus.mem_en, exp_en);
      end
      if (bus.mem_we !== (exp_en && m_we)) begin
        fails++;
        $display("[TB] FAIL rnd_mem_we c%0d got=%b expected=%b", cyc, bus.mem_we, exp_en && m_we);
      end
      if (bus.core_done !== exp_cd) begin
        fails++;
        $display("[TB] FAIL rnd_core_done c%0d got=%b expected=%b", cyc, bus.core_done, exp_cd);
      end
      if (bus.ldr_ack !== exp_la) begin
        fails++;
        $display("[TB] FAIL rnd_ldr_ack c%0d got=%b expected=%b", cyc, bus.ldr_ack, exp_la);
      end
      if (bus.core_rdata !== m_core_rdata) begin
        fails++;
        $display("[TB] FAIL rnd_core_rdata c%0d got=%h expected=%h", cyc, bus.core_rdata, m_core_rdata);
      end
      if (bus.ldr_rdata !== m_ldr_rdata) begin
        fails++;
        $display("[TB] FAIL rnd_ldr_rdata c%0d got=%h expected=%h", cyc, bus.ldr_rdata, m_ldr_rdata);
      end
      if (exp_en) begin
        tests_run++;
        if (bus.mem_addr !== m_addr || (m_we && bus.mem_wdata !== m_wdata)) begin
          fails++;
          $display("[TB] FAIL rnd_mem_bus c%0d got=%h/%h expected=%h/%h", cyc, bus.mem_addr, bus.mem_wdata, m_addr, m_wdata);
        end
      end
      bus.core_req   = ($urandom_range(0, 99) < pc);
      bus.core_we    = 1'($urandom);
      bus.core_addr  = $urandom;
      bus.core_wdata = $urandom;
      bus.ldr_req    = ($urandom_range(0, 99) < pl);
      bus.ldr_we     = 1'($urandom);
      bus.ldr_addr   = $urandom;
      bus.ldr_wdata  = $urandom;
      bus.mem_rdata  = $urandom;
      if (m_busy && cyc == m_a + W) m_pend = bus.mem_rdata;
      #1;
      tests_run++;
      if (bus.core_stall !== (bus.core_req && !exp_cd)) begin
        fails++;
        $display("[TB] FAIL rnd_stall c%0d got=%b expected=%b", cyc, bus.core_stall, bus.core_req && !exp_cd);
      end
      if (cyc >= m_next && (bus.core_req || bus.ldr_req)) begin
        if (bus.ldr_req && (!bus.core_req || (FAIR && m_starve >= SL))) begin
          m_owner  = 1'b1;
          m_starve = 0;
          m_we     = bus.ldr_we;
          m_addr   = bus.ldr_addr;
          m_wdata  = bus.ldr_wdata;
        end else begin
          m_owner  = 1'b0;
          m_starve = bus.ldr_req ? m_starve + 1 : 0;
          m_we     = bus.core_we;
          m_addr   = bus.core_addr;
          m_wdata  = bus.core_wdata;
        end
        m_busy = 1'b1;
        m_a    = cyc;
        m_next = cyc + W + 2;
      end
      tick();
      cyc++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_core_read();
    test_simultaneous();
    test_loader_write();
    test_reset_mid_access();
    test_drop_mid_access();
    test_starvation();
    test_random(400, 60, 40);
    test_random(120, 100, 100);
    test_random(200, 20, 70);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: cycles mem_en is held per access (legal range 1..15).
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive core grants tolerated while loader waits (used only under DMEM_ARB_FAIR_EN).
REQ-003 Clock and reset: clk  in  1  single clock, all state on rising edge; rst  in  1  asynchronous, active-low reset.
REQ-004 core_req  in  1  memory stage requests an access; core_we  in  1  write when 1; core_addr  in  32; core_wdata  in  32.
REQ-005 core_rdata  out  32  registered read data; core_done  out  1  one-cycle completion pulse; core_stall  out  1  hold pipeline.
REQ-006 ldr_req  in  1  loader/debug requests an access; ldr_we  in  1; ldr_addr  in  32; ldr_wdata  in  32.
REQ-007 ldr_rdata  out  32  registered read data; ldr_ack  out  1  one-cycle completion pulse.
REQ-008 mem_en  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32; mem_rdata  in  32  data memory port.

Function
REQ-009 FSM states IDLE, ACCESS, RESP; IDLE entered from reset.
REQ-010 IDLE with any request: select owner, latch owner's we/addr/wdata, load wait counter with WAIT_CYCLES-1, go ACCESS next edge.
REQ-011 IDLE with no request: remain IDLE, mem_en=0.
REQ-012 Arbitration default: core strict priority over loader on simultaneous requests.
REQ-013 ACCESS: mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values; counter decrements each cycle; at counter 0 go RESP.
REQ-014 On the last ACCESS cycle of a read, capture mem_rdata into the owner's rdata register; writes leave both rdata registers unchanged.
REQ-015 RESP: pulse core_done or ldr_ack (owner only) for exactly one cycle, mem_en=0, return to IDLE.
REQ-016 Latency: request seen in IDLE at cycle 0 -> done/ack pulse in cycle WAIT_CYCLES+1; next arbitration no earlier than cycle WAIT_CYCLES+2.
REQ-017 core_stall = core_req AND NOT core_done (combinational).
REQ-018 Request inputs changing or deasserting during ACCESS/RESP are ignored; the latched access completes and still pulses.
REQ-019 mem_we SHALL never be 1 while mem_en is 0.

Reset
REQ-020 rst low: state=IDLE, counters=0, core_rdata=0, ldr_rdata=0, core_done=0, ldr_ack=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, immediately.
REQ-021 Reset mid-ACCESS aborts the access: no done/ack pulse, no rdata update.
REQ-022 First arbitration after release occurs on the first rising edge with rst high.

Configuration
REQ-023 Macro DMEM_ARB_FAIR_EN defined: starve counter increments on each core grant made while ldr_req=1; at STARVE_LIMIT with ldr_req=1, loader wins; counter clears on loader grant or when ldr_req=0 at arbitration.
REQ-024 Macro undefined: no starve counter logic; strict core priority per REQ-012.

Structure
REQ-025 State encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and owner encoding (CORE=1'b0, LDR=1'b1) live in shared package dmem_arb_pkg.
REQ-026 Wait counter implemented as sub-module dmem_wait_counter (load, decrement, zero flag); FSM and arbitration stay in dmem_arbiter.

Verification
REQ-027 Core read addr 0x0000_0010, mem_rdata=0xDEAD_BEEF, WAIT_CYCLES=2 -> mem_en high cycles 1-2, core_done pulse cycle 3, core_rdata=0xDEAD_BEEF, core_stall low in cycle 3 only.
REQ-028 Core and loader request same cycle -> core served first, loader ack pulse in cycle 7 (WAIT_CYCLES=2).
REQ-029 Loader write addr 0x40 data 0x1234_5678 -> mem_we=1 with mem_en for 2 cycles, ldr_ack one pulse, ldr_rdata unchanged.
REQ-030 rst asserted during second ACCESS cycle -> all outputs 0 asynchronously, no done pulse after release.
REQ-031 DMEM_ARB_FAIR_EN, STARVE_LIMIT=4, core_req and ldr_req held high -> grants CORE x4, LDR x1, repeating; undefined -> CORE only.
REQ-032 core_req dropped mid-ACCESS -> access completes, core_done still pulses once.
